// File: rtl/aes_pkg.sv
// Shared types and sizes for the AES S-box scheduling engine.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_WORD_W  = 32;
    localparam int AES_NCOL    = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ST_RUN,
        S_KW_RUN,
        S_ACK
    } sched_state_e;

    typedef enum logic {
        GNT_ST,
        GNT_KW
    } grant_e;

endpackage

// File: rtl/sbox_scheduler_softbox.sv
// Combinational AES byte S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module sbox_scheduler_softbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the inverse for x != 0 and maps 0 to 0, as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] v);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        dout = affine(gf_inv(din));
    end

endmodule

// File: rtl/sbox_scheduler.sv
// Round-robin scheduler sharing S-box lanes between state SubBytes and key SubWord.
// Build option SBOX_SCHED_PARALLEL_EN: 16 lanes, whole state substituted in one cycle.
module sbox_scheduler
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   st_req,
    input  logic [AES_STATE_W-1:0] st_data,
    output logic                   st_ack,
    output logic [AES_STATE_W-1:0] st_result,
    input  logic                   kw_req,
    input  logic [AES_WORD_W-1:0]  kw_data,
    output logic                   kw_ack,
    output logic [AES_WORD_W-1:0]  kw_result,
    output logic                   busy
);

`ifdef SBOX_SCHED_PARALLEL_EN
    localparam int NLANE = 4 * AES_NCOL;
`else
    localparam int NLANE = AES_NCOL;
`endif

    sched_state_e           state_q, state_d;
    grant_e                 last_grant_q, last_grant_d;
    logic [AES_STATE_W-1:0] st_lat_q, st_lat_d;
    logic [AES_STATE_W-1:0] st_result_q, st_result_d;
    logic [AES_WORD_W-1:0]  kw_lat_q, kw_lat_d;
    logic [AES_WORD_W-1:0]  kw_result_q, kw_result_d;
    logic                   st_ack_q, st_ack_d;
    logic                   kw_ack_q, kw_ack_d;
`ifndef SBOX_SCHED_PARALLEL_EN
    logic [1:0]             col_q, col_d;
    logic [AES_STATE_W-1:0] buf_q, buf_d;
`else
    logic [AES_STATE_W-1:0] lane_state;
`endif

    logic [7:0]             lane_in  [NLANE];
    logic [7:0]             lane_out [NLANE];
    logic [AES_WORD_W-1:0]  lane_word;

    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        sbox_scheduler_softbox u_sbox (
            .din  (lane_in[i]),
            .dout (lane_out[i])
        );
    end

    always_comb begin
        for (int i = 0; i < AES_NCOL; i++) begin
            lane_word[AES_WORD_W-1-8*i -: 8] = lane_out[i];
        end
    end

`ifdef SBOX_SCHED_PARALLEL_EN
    always_comb begin
        for (int i = 0; i < NLANE; i++) begin
            lane_state[AES_STATE_W-1-8*i -: 8] = lane_out[i];
        end
    end
`endif

    // Lanes 0..3 carry the key word during KW_RUN, otherwise the selected state column(s).
    always_comb begin
        for (int i = 0; i < NLANE; i++) begin
            lane_in[i] = 8'h00;
        end
        if (state_q == S_KW_RUN) begin
            for (int i = 0; i < AES_NCOL; i++) begin
                lane_in[i] = kw_lat_q[AES_WORD_W-1-8*i -: 8];
            end
        end else begin
`ifdef SBOX_SCHED_PARALLEL_EN
            for (int i = 0; i < NLANE; i++) begin
                lane_in[i] = st_lat_q[AES_STATE_W-1-8*i -: 8];
            end
`else
            for (int c = 0; c < AES_NCOL; c++) begin
                if (col_q == 2'(c)) begin
                    for (int i = 0; i < AES_NCOL; i++) begin
                        lane_in[i] = st_lat_q[AES_STATE_W-1-32*c-8*i -: 8];
                    end
                end
            end
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        st_lat_d     = st_lat_q;
        kw_lat_d     = kw_lat_q;
        st_result_d  = st_result_q;
        kw_result_d  = kw_result_q;
        st_ack_d     = 1'b0;
        kw_ack_d     = 1'b0;
`ifndef SBOX_SCHED_PARALLEL_EN
        col_d        = col_q;
        buf_d        = buf_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Under contention the requester that did not win last time goes first.
                if (st_req && (!kw_req || last_grant_q == GNT_KW)) begin
                    state_d      = S_ST_RUN;
                    last_grant_d = GNT_ST;
                    st_lat_d     = st_data;
`ifndef SBOX_SCHED_PARALLEL_EN
                    col_d        = 2'd0;
`endif
                end else if (kw_req) begin
                    state_d      = S_KW_RUN;
                    last_grant_d = GNT_KW;
                    kw_lat_d     = kw_data;
                end
            end
            S_ST_RUN: begin
`ifdef SBOX_SCHED_PARALLEL_EN
                st_result_d = lane_state;
                st_ack_d    = 1'b1;
                state_d     = S_ACK;
`else
                for (int c = 0; c < AES_NCOL; c++) begin
                    if (col_q == 2'(c)) begin
                        buf_d[AES_STATE_W-1-32*c -: 32] = lane_word;
                    end
                end
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    st_result_d = buf_d;
                    st_ack_d    = 1'b1;
                    state_d     = S_ACK;
                end
`endif
            end
            S_KW_RUN: begin
                kw_result_d = lane_word;
                kw_ack_d    = 1'b1;
                state_d     = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= GNT_KW;
            st_lat_q     <= '0;
            kw_lat_q     <= '0;
            st_result_q  <= '0;
            kw_result_q  <= '0;
            st_ack_q     <= 1'b0;
            kw_ack_q     <= 1'b0;
`ifndef SBOX_SCHED_PARALLEL_EN
            col_q        <= 2'd0;
            buf_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            st_lat_q     <= st_lat_d;
            kw_lat_q     <= kw_lat_d;
            st_result_q  <= st_result_d;
            kw_result_q  <= kw_result_d;
            st_ack_q     <= st_ack_d;
            kw_ack_q     <= kw_ack_d;
`ifndef SBOX_SCHED_PARALLEL_EN
            col_q        <= col_d;
            buf_q        <= buf_d;
`endif
        end
    end

    assign st_ack    = st_ack_q;
    assign kw_ack    = kw_ack_q;
    assign st_result = st_result_q;
    assign kw_result = kw_result_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sbox_scheduler.sv
// Self-checking bench for sbox_scheduler: directed scenarios plus randomized requesters against a transaction-level model.
module tb_sbox_scheduler;

`ifdef SBOX_SCHED_PARALLEL_EN
    localparam int L_ST = 1;
`else
    localparam int L_ST = 4;
`endif
    localparam int L_KW = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         st_req = 1'b0;
    logic [127:0] st_data = '0;
    logic         kw_req = 1'b0;
    logic [31:0]  kw_data = '0;
    logic         st_ack, kw_ack, busy;
    logic [127:0] st_result;
    logic [31:0]  kw_result;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    sbox_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_req    (st_req),
        .st_data   (st_data),
        .st_ack    (st_ack),
        .st_result (st_result),
        .kw_req    (kw_req),
        .kw_data   (kw_data),
        .kw_ack    (kw_ack),
        .kw_result (kw_result),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sbox_ref(input logic [7:0] v);
        logic [127:0] row;
        int idx;
        case (v[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        idx = int'(v[3:0]);
        return row[127-8*idx -: 8];
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] x);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[127-8*b -: 8] = sbox_ref(x[127-8*b -: 8]);
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[31-8*b -: 8] = sbox_ref(x[31-8*b -: 8]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Model: engine occupancy countdown; results publish on the last busy-edge before ACK ends.
    int           m_cnt = 0;
    bit           m_owner_st = 1'b0;
    bit           m_last_st = 1'b0;
    logic [127:0] m_st_pend = '0, m_st_res = '0;
    logic [31:0]  m_kw_pend = '0, m_kw_res = '0;
    bit           m_st_ack = 1'b0, m_kw_ack = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_owner_st = 1'b0; m_last_st = 1'b0;
            m_st_pend = '0; m_st_res = '0; m_kw_pend = '0; m_kw_res = '0;
            m_st_ack = 1'b0; m_kw_ack = 1'b0;
        end else begin
            m_st_ack = 1'b0;
            m_kw_ack = 1'b0;
            if (m_cnt == 0) begin
                if (st_req && (!kw_req || !m_last_st)) begin
                    m_owner_st = 1'b1; m_last_st = 1'b1;
                    m_st_pend = sub_state(st_data);
                    m_cnt = L_ST + 1;
                end else if (kw_req) begin
                    m_owner_st = 1'b0; m_last_st = 1'b0;
                    m_kw_pend = sub_word(kw_data);
                    m_cnt = L_KW + 1;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 1) begin
                    if (m_owner_st) begin m_st_res = m_st_pend; m_st_ack = 1'b1; end
                    else begin m_kw_res = m_kw_pend; m_kw_ack = 1'b1; end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_cnt != 0);
        chk("st_ack", st_ack, m_st_ack);
        chk("kw_ack", kw_ack, m_kw_ack);
        chk("st_result", st_result, m_st_res);
        chk("kw_result", kw_result, m_kw_res);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_st_ack;
        int t = 0;
        while (!st_ack && t < 60) begin tick(); t++; end
        if (!st_ack) chk("st_ack_timeout", st_ack, 1);
    endtask

    task automatic wait_kw_ack;
        int t = 0;
        while (!kw_ack && t < 60) begin tick(); t++; end
        if (!kw_ack) chk("kw_ack_timeout", kw_ack, 1);
    endtask

    task automatic pulse_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int gk, a1, a2, n;
        int t;
        bit [1:0] order [3];
        int st_seen;
        logic [127:0] p;
        logic [31:0]  q;

        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_st_ack", st_ack, 0);
        chk("reset_kw_ack", kw_ack, 0);
        chk("reset_st_result", st_result, 0);
        chk("reset_kw_result", kw_result, 0);
        rst_n = 1'b1;
        tick();

        // Zero state
        st_data = '0; st_req = 1'b1;
        tick(); gk = cyc;
        chk("A_busy_on_grant", busy, 1);
        wait_st_ack();
        chk("A_ack_latency", cyc - gk, L_ST);
        chk("A_result", st_result, {16{8'h63}});
        chk("A_model_pin", m_st_res, {16{8'h63}});
        st_req = 1'b0;
        tick();
        chk("A_busy_fall", busy, 0);
        chk("A_busy_cycles", cyc - gk, L_ST + 1);
        tick();

        // Key word
        kw_data = 32'h00010253; kw_req = 1'b1;
        tick(); gk = cyc;
        wait_kw_ack();
        chk("B_ack_latency", cyc - gk, L_KW);
        chk("B_result", kw_result, 32'h637C77ED);
        chk("B_st_hold", st_result, {16{8'h63}});
        kw_req = 1'b0;
        tick(); tick();

        // Contention after reset: state, then key, then state re-request
        pulse_reset();
        st_req = 1'b1; st_data = {4{$urandom}};
        kw_req = 1'b1; kw_data = $urandom;
        n = 0; st_seen = 0; t = 0;
        while (n < 3 && t < 80) begin
            tick(); t++;
            if (st_ack) begin
                order[n] = 2'd1; n++;
                if (st_seen == 0) st_data = {4{$urandom}};
                else st_req = 1'b0;
                st_seen++;
            end
            if (kw_ack && n < 3) begin
                order[n] = 2'd2; n++;
                kw_req = 1'b0;
            end
        end
        chk("C_count", n, 3);
        chk("C_first_state", order[0], 2'd1);
        chk("C_second_key", order[1], 2'd2);
        chk("C_third_state", order[2], 2'd1);
        st_req = 1'b0; kw_req = 1'b0;
        tick(); tick(); tick();

        // Reset in the middle of a state operation
        st_data = {16{8'hFF}}; st_req = 1'b1;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("D_busy_now", busy, 0);
        chk("D_st_ack_now", st_ack, 0);
        chk("D_st_result_now", st_result, 0);
        chk("D_kw_result_now", kw_result, 0);
        tick(); tick();
        rst_n = 1'b1;
        wait_st_ack();
        chk("D_result", st_result, {16{8'h16}});
        st_req = 1'b0;
        tick(); tick();

        // Back-to-back state with new data in the ACK cycle
        st_data = {4{$urandom}}; st_req = 1'b1;
        tick();
        wait_st_ack(); a1 = cyc;
        st_data = {16{8'h53}};
        tick();
        wait_st_ack(); a2 = cyc;
        chk("E_spacing", a2 - a1, L_ST + 2);
        chk("E_result", st_result, {16{8'hED}});
        st_req = 1'b0;
        tick(); tick();

        // Key arrives mid state-op, state data scrambled after grant
        p = {4{$urandom}}; q = $urandom;
        st_data = p; st_req = 1'b1;
        tick(); tick();
        kw_req = 1'b1; kw_data = q;
        st_data = ~p;
        wait_st_ack(); a1 = cyc;
        chk("F_st_result", st_result, sub_state(p));
        st_req = 1'b0;
        tick();
        wait_kw_ack();
        chk("F_kw_spacing", cyc - a1, 3);
        chk("F_kw_result", kw_result, sub_word(q));
        kw_req = 1'b0;
        tick(); tick();

        // Randomized requesters with occasional resets
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!st_req) begin
                if ($urandom_range(0, 3) == 0) begin st_req = 1'b1; st_data = {4{$urandom}}; end
            end else if (st_ack) begin
                if ($urandom_range(0, 1) == 0) st_req = 1'b0;
                else st_data = {4{$urandom}};
            end else if ($urandom_range(0, 7) == 0) begin
                st_data = {4{$urandom}};
            end
            if (!kw_req) begin
                if ($urandom_range(0, 3) == 0) begin kw_req = 1'b1; kw_data = $urandom; end
            end else if (kw_ack) begin
                if ($urandom_range(0, 1) == 0) kw_req = 1'b0;
                else kw_data = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
                kw_data = $urandom;
            end
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
        end
        rst_n = 1'b1;
        st_req = 1'b0; kw_req = 1'b0;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
